// File: rtl/phase_seq.sv
// Burst phase sequencer driving an external 3-bit enabled counter.
// Optional pause input enabled by defining PHASE_SEQ_HOLD_EN.
module phase_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] len,
    input  logic [2:0] count,
`ifdef PHASE_SEQ_HOLD_EN
    input  logic       hold,
`endif
    output logic       cnten,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase,
    output logic [7:0] ph
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] base;
    logic [2:0] lenr;
    logic       accept;
    logic       last;
    logic       hold_w;

`ifdef PHASE_SEQ_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Relative phase wraps naturally with the 3-bit counter.
    assign phase = count - base;
    assign last  = (phase == lenr);
    assign accept = start && (state != RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            base  <= 3'd0;
            lenr  <= 3'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                base <= count;
                lenr <= len;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnten   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        ph      = 8'd0;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_n = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                ph    = 8'd1 << phase;
                cnten = ~hold_w & ~last;
                if (~hold_w && last)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = accept ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_phase_seq.sv
// Directed bench for phase_seq with a behavioural 3-bit counter.
// Define PHASE_SEQ_HOLD_EN to exercise the pause input.
module tb_phase_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] len = 3'd0;
    logic [2:0] count = 3'd0;
    logic       cnt_ld = 1'b0;
    logic [2:0] cnt_val = 3'd0;
`ifdef PHASE_SEQ_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic       cnten;
    logic       busy;
    logic       done;
    logic [2:0] phase;
    logic [7:0] ph;

    int n_chk = 0;
    int n_err = 0;

    phase_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .count (count),
`ifdef PHASE_SEQ_HOLD_EN
        .hold  (hold),
`endif
        .cnten (cnten),
        .busy  (busy),
        .done  (done),
        .phase (phase),
        .ph    (ph)
    );

    always #5 clk = ~clk;

    // Downstream counter: mod-8, advances one edge after cnten.
    always @(posedge clk) begin
        if (cnt_ld)
            count <= cnt_val;
        else if (cnten)
            count <= count + 3'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic b,
                           input logic d, input logic c,
                           input logic [7:0] p);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".cnten"}, 32'(cnten), 32'(c));
        chk({tag, ".ph"}, 32'(ph), 32'(p));
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic burst(input string tag, input logic [2:0] l,
                         input logic [2:0] c0);
        logic [2:0] ec;
        @(negedge clk);
        cnt_ld  = 1'b1;
        cnt_val = c0;
        @(negedge clk);
        cnt_ld = 1'b0;
        start  = 1'b1;
        len    = l;
        #1;
        chk_out({tag, ".pre"}, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        start = 1'b0;
        #1;
        for (int i = 0; i <= int'(l); i++) begin
            ec = c0 + 3'(i);
            chk_out($sformatf("%s.run%0d", tag, i), 1'b1, 1'b0,
                    i != int'(l), 8'd1 << i);
            chk($sformatf("%s.phase%0d", tag, i), 32'(phase), i);
            chk($sformatf("%s.count%0d", tag, i), 32'(count), 32'(ec));
            step();
        end
        ec = c0 + l;
        chk_out({tag, ".done"}, 1'b0, 1'b1, 1'b0, 8'h00);
        chk({tag, ".endcount"}, 32'(count), 32'(ec));
        step();
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk_out("rst", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst.phase", 32'(phase), 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk_out("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        burst("full", 3'd7, 3'd0);
        burst("wrap", 3'd4, 3'd5);
        burst("len0", 3'd0, 3'd2);
        burst("len3", 3'd3, 3'd6);

        // Back-to-back with start held high.
        @(negedge clk);
        cnt_ld  = 1'b1;
        cnt_val = 3'd1;
        @(negedge clk);
        cnt_ld = 1'b0;
        start  = 1'b1;
        len    = 3'd2;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("b2b.a%0d", i), 1'b1, 1'b0, i != 2,
                    8'd1 << i);
            chk($sformatf("b2b.aph%0d", i), 32'(phase), i);
            step();
        end
        chk_out("b2b.done", 1'b0, 1'b1, 1'b0, 8'h00);
        step();
        chk_out("b2b.b0", 1'b1, 1'b0, 1'b1, 8'h01);
        chk("b2b.bphase", 32'(phase), 0);
        chk("b2b.bcount", 32'(count), 3);
        start = 1'b0;
        step();
        step();
        chk_out("b2b.b2", 1'b1, 1'b0, 1'b0, 8'h04);
        step();
        chk_out("b2b.bdone", 1'b0, 1'b1, 1'b0, 8'h00);
        step();

        // Abort at phase 3 of a len=7 burst.
        @(negedge clk);
        cnt_ld  = 1'b1;
        cnt_val = 3'd0;
        @(negedge clk);
        cnt_ld = 1'b0;
        start  = 1'b1;
        len    = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort.phase", 32'(phase), 3);
        reset = 1'b1;
        #1;
        chk_out("abort.rst", 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        chk_out("abort.hold", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("abort.count", 32'(count), 3);
        @(negedge clk);
        reset = 1'b0;
        burst("post", 3'd1, 3'd3);

`ifdef PHASE_SEQ_HOLD_EN
        // Pause two cycles at phase 1, then pause at the last phase.
        @(negedge clk);
        start = 1'b1;
        len   = 3'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_out("hold.p0", 1'b1, 1'b0, 1'b1, 8'h01);
        step();
        hold = 1'b1;
        #1;
        chk_out("hold.h1", 1'b1, 1'b0, 1'b0, 8'h02);
        step();
        chk_out("hold.h2", 1'b1, 1'b0, 1'b0, 8'h02);
        chk("hold.phase", 32'(phase), 1);
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk_out("hold.r1", 1'b1, 1'b0, 1'b1, 8'h02);
        step();
        chk_out("hold.p2", 1'b1, 1'b0, 1'b1, 8'h04);
        step();
        chk_out("hold.p3", 1'b1, 1'b0, 1'b0, 8'h08);
        step();
        chk_out("hold.done", 1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        start = 1'b1;
        len   = 3'd0;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b1;
        #1;
        chk_out("hlast.h", 1'b1, 1'b0, 1'b0, 8'h01);
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk_out("hlast.run", 1'b1, 1'b0, 1'b0, 8'h01);
        step();
        chk_out("hlast.done", 1'b0, 1'b1, 1'b0, 8'h00);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
